// File: rtl/enc_pkg.sv
// Shared types and defaults for the serial 8-to-3 encoder (enc_serial).
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  localparam int ENC_N_DEF = 8;

endpackage

// File: rtl/enc_serial_prio_enc.sv
// prio_enc: combinational highest-set-bit encoder; idx is 0 when the input is all zero.
module prio_enc #(
  parameter int N  = 8,
  parameter int XW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [XW-1:0] idx,
  output logic          any
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = XW'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/enc_serial.sv
// enc_serial: captures a request vector and streams the index of each set bit, highest first.
// Optional macro ENC_COUNT_EN adds the cnt output (remaining indices in the current vector).
module enc_serial
  import enc_pkg::*;
#(
  parameter int N  = ENC_N_DEF,
  parameter int XW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [N-1:0]  D,
  output logic [XW-1:0] X,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          done
`ifdef ENC_COUNT_EN
  ,
  output logic [XW:0]   cnt
`endif
);

  enc_state_t    r_state;
  logic [N-1:0]  r_pend;
  logic [XW-1:0] r_x;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  logic [N-1:0]  w_clear;
  logic [N-1:0]  w_pend_next;
  logic [XW-1:0] w_idx;
  logic          w_any;
  logic          w_load_ok;
  logic          w_xfer;

  assign w_load_ok = (r_state == IDLE) && load && (|D);
  assign w_xfer    = (r_state == RUN) && ready;

  // One-hot mask of the index currently presented on X.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clear
      assign w_clear[gi] = (r_x == XW'(gi));
    end
  endgenerate

  // Next pending set; encoding it lets X be registered together with pend.
  always_comb begin
    w_pend_next = r_pend;
    if (w_load_ok) begin
      w_pend_next = D;
    end else if (w_xfer) begin
      w_pend_next = r_pend & ~w_clear;
    end
  end

  prio_enc #(
    .N  (N),
    .XW (XW)
  ) u_prio_enc (
    .req (w_pend_next),
    .idx (w_idx),
    .any (w_any)
  );

`ifdef ENC_COUNT_EN
  logic [XW:0] r_cnt;

  function automatic logic [XW:0] f_popcount(input logic [N-1:0] v);
    logic [XW:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + (XW+1)'(v[i]);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load_ok) begin
      r_cnt <= f_popcount(D);
    end else if (w_xfer) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt = r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_x     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            if (|D) begin
              r_pend  <= w_pend_next;
              r_x     <= w_idx;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= RUN;
            end else begin
              // Empty vector: nothing to send, just acknowledge it.
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ready) begin
            r_pend <= w_pend_next;
            r_x    <= w_idx;
            if (!w_any) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign X     = r_x;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: doc/enc_serial.md
# enc_serial

Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder. It captures an 8-bit request vector `D` and emits the 3-bit index `X` of every set bit, one index per accepted handshake. Indices come out in descending priority, highest bit first. The block sits upstream of the decoder path and turns multi-hot request words into a stream of binary codes.

## Interface
Parameters:
- `N`, 8: width of the request vector; must be a power of two, ≥ 2.
- `XW`, `$clog2(N)`: width of the index output; derived, not overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset; one clock, with synchronous active-high reset (fixed).
- `load`  in  1  capture request `D`; honoured only when `busy`=0.
- `D`  in  N  request vector; bit i set means emit index i.
- `X`  out  XW  current index; meaningful only when `valid`=1.
- `valid`  out  1  `X` holds an unsent index.
- `ready`  in  1  downstream accepts `X`; a transfer occurs when `valid`&&`ready`.
- `busy`  out  1  vector in progress; `load` is ignored.
- `done`  out  1  one-cycle pulse after the last index of a vector, or after an all-zero load.

## Operation
- State machine in `enc_state_t`, with two states:
  - IDLE: `busy`=0, `valid`=0.
  - RUN: `busy`=1, `valid`=1.
- IDLE with `load`=1 and `D`≠0: `pend` ← `D`, go to RUN.
- IDLE with `load`=1 and `D`=0: stay in IDLE; `done`=1 on the next cycle; no `valid` ever asserts.
- RUN:
  - `X` = index of the highest set bit of `pend`, from a combinational priority encode registered into `X`.
  - On a transfer, clear that bit of `pend`.
  - If the cleared bit was the last set bit, go to IDLE and pulse `done`.
  - Otherwise stay in RUN with `X` set to the next-lower set bit.
- `ready`=0 in RUN: hold `X`, `valid` and `pend` unchanged; there is no timeout.
- `load` in RUN is ignored; `D` is don't-care.
- `load` in the same cycle as the final transfer is ignored; the source loads only after it sees `busy`=0.
- Exactly popcount(`D`) transfers are produced per vector. Indices are strictly decreasing and unique.

## Timing
- Reset values: `X`=0, `valid`=0, `busy`=0, `done`=0, `pend`=0, state=IDLE.
- `rst` mid-vector discards the remaining bits. No `done` is produced for the discarded vector.
- Load-to-first-valid latency: 1 cycle (`load` sampled at edge k; `valid`=1 after edge k).
- Throughput: 1 index per cycle while `ready`=1. A vector with k set bits finishes in k+1 cycles from load, counting the `done` cycle.
- `done` is high for exactly one cycle, the cycle after the final transfer; `valid`=0 and `busy`=0 in that cycle.
- Outputs are registered; there is no combinational path from `ready` or `D` to any output.

## Configuration
- `ENC_COUNT_EN` defined: adds output `cnt` (width XW+1).
  - Reset value 0.
  - Loaded with popcount(`D`) on an accepted load.
  - Decremented on each transfer, so it reads 0 in the `done` cycle.
- `ENC_COUNT_EN` undefined: the `cnt` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `enc_pkg`:
  - `enc_state_t` (IDLE, RUN).
  - Localparam `ENC_N_DEF`=8.
- Sub-module `prio_enc`: combinational N-to-XW highest-set-bit encoder.
  - Outputs `idx` and `any`.
  - `idx`=0 when the input is 0.
  - Instantiated once on `pend`.

## Test plan
- Reset, then `load` with `D`=8'b0000_0100, `ready`=1 -> next cycle `valid`=1, `X`=3'd2; following cycle `valid`=0, `done`=1, `busy`=0.
- `D`=8'b1010_0101, `ready`=1 -> `X` sequence 7, 5, 2, 0 on consecutive cycles, then a single `done` pulse.
- Same `D`, `ready` toggled 1,0,0,1,1,0,1 -> `X` stays stable while stalled; still exactly 7, 5, 2, 0 transferred; `done` one cycle after the 4th transfer.
- `load` with `D`=8'h00 -> `valid` never 1; `done`=1 one cycle later; `busy` stays 0.
- `D`=8'hFF; assert `rst` after 3 transfers -> next cycle all outputs 0; a new load of `D`=8'h01 yields `X`=0 with no stale indices.
- `ENC_COUNT_EN` build, `D`=8'b1100_0001 -> `cnt`=3 after load, then 2, 1, 0 across the transfers; a `load` while `busy`=1 changes nothing.
